// File: rtl/pair_parity_rx_if.sv
// Bus bundle for pair_parity_rx: serial bit input plus the valid/ready frame output.
// The master modport is the driving side (line + consumer); slave is the receiver.
interface pair_parity_rx_if;
    logic       din;
    logic       din_valid;
    logic [3:0] data;
    logic [1:0] err;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       busy;
    logic       abort;

    modport master (
        output din, din_valid, out_ready,
        input  data, err, out_valid, overrun, busy, abort
    );

    modport slave (
        input  din, din_valid, out_ready,
        output data, err, out_valid, overrun, busy, abort
    );
endinterface

// File: rtl/pair_parity_rx.sv
// pair_parity_rx: collects start, d3..d0, rx_p1, rx_p0 and flags pair-XOR parity errors.
// Define PAIR_PARITY_RX_TIMEOUT_EN to abort frames after TIMEOUT idle cycles mid-frame.
module pair_parity_rx #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            reset,
    pair_parity_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;

    state_t     state, state_next;
    logic [1:0] bit_cnt;
    logic [3:0] data_q;
    logic [1:0] err_q;
    logic       rx_p1;
    logic       overrun_q;
    logic       abort_q;

    logic start_bit;
    logic transfer;
    logic last_data;
    logic last_parity;
    logic timeout_hit;

    assign start_bit   = bus.din_valid && bus.din;
    assign transfer    = (state == HOLD) && bus.out_ready;
    assign last_data   = bus.din_valid && (bit_cnt == 2'd3);
    assign last_parity = bus.din_valid && bit_cnt[0];

`ifdef PAIR_PARITY_RX_TIMEOUT_EN
    logic [7:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            gap_cnt <= '0;
        else if ((state != DATA && state != PARITY) || bus.din_valid || timeout_hit)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 8'd1;
    end

    // Fires on the edge that would make the gap count equal TIMEOUT.
    assign timeout_hit = (state == DATA || state == PARITY) && !bus.din_valid &&
                         (gap_cnt == 8'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:   if (start_bit) state_next = DATA;
            DATA:   if (timeout_hit) state_next = IDLE;
                    else if (last_data) state_next = PARITY;
            PARITY: if (timeout_hit) state_next = IDLE;
                    else if (last_parity) state_next = HOLD;
            HOLD:   if (transfer) state_next = start_bit ? DATA : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            data_q    <= '0;
            err_q     <= '0;
            rx_p1     <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
            if (state == HOLD && !transfer && bus.din_valid)
                overrun_q <= 1'b1;

            case (state)
                // bit_cnt wraps 3 -> 0 on d0, ready for the parity phase.
                DATA: if (bus.din_valid) begin
                    data_q  <= {data_q[2:0], bus.din};
                    bit_cnt <= bit_cnt + 2'd1;
                end
                PARITY: if (bus.din_valid) begin
                    if (!bit_cnt[0]) begin
                        rx_p1   <= bus.din;
                        bit_cnt <= 2'd1;
                    end else begin
                        err_q   <= {rx_p1 ^ data_q[3] ^ data_q[2],
                                    bus.din ^ data_q[1] ^ data_q[0]};
                        bit_cnt <= 2'd0;
                    end
                end
                default: ;
            endcase

            if (timeout_hit)
                bit_cnt <= '0;
        end
    end

    assign bus.data      = data_q;
    assign bus.err       = err_q;
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == DATA) || (state == PARITY);
    assign bus.overrun   = overrun_q;
    assign bus.abort     = abort_q;
endmodule

// File: tb/tb_pair_parity_rx.sv
// Self-checking bench for pair_parity_rx: vector table, directed corner cases,
// then random traffic against a queue-based frame model.
module tb_pair_parity_rx;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pair_parity_rx_if bus ();

    pair_parity_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bits of the current frame kept in a queue.
    bit         m_bits[$];
    bit         m_hold;
    logic [3:0] m_data;
    logic [1:0] m_err;
    bit         m_ovr;
    bit         m_abort;
    int         m_gap;

    function void model_step(input bit rst, input bit dv, input bit d, input bit rdy);
        m_abort = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_hold = 1'b0;
            m_data = '0;
            m_err  = '0;
            m_ovr  = 1'b0;
            m_gap  = 0;
            return;
        end
        if (m_hold) begin
            if (rdy) begin
                m_hold = 1'b0;
                if (dv && d) m_bits.push_back(1'b1);
            end else if (dv) begin
                m_ovr = 1'b1;
            end
        end else if (dv) begin
            if (m_bits.size() != 0 || d) m_bits.push_back(d);
            m_gap = 0;
            if (m_bits.size() == 7) begin
                m_data = {m_bits[1], m_bits[2], m_bits[3], m_bits[4]};
                m_err  = {m_bits[5] ^ m_bits[1] ^ m_bits[2], m_bits[6] ^ m_bits[3] ^ m_bits[4]};
                m_hold = 1'b1;
                m_bits.delete();
            end
        end else if (m_bits.size() != 0) begin
`ifdef PAIR_PARITY_RX_TIMEOUT_EN
            m_gap++;
            if (m_gap == TIMEOUT) begin
                m_bits.delete();
                m_abort = 1'b1;
                m_gap   = 0;
            end
`endif
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic dv, input logic d, input logic rdy);
        reset         = rst;
        bus.din_valid = dv;
        bus.din       = d;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
        model_step(rst, dv, d, rdy);
    endtask

    task automatic send_frame(input logic [6:0] bits, input logic rdy);
        for (int i = 6; i >= 0; i--) step(1'b0, 1'b1, bits[i], rdy);
    endtask

    typedef struct {
        logic [6:0] bits;
        logic [3:0] data;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // start, d3..d0, rx_p1, rx_p0
        vecs[0] = '{bits: 7'b1101110, data: 4'b1011, err: 2'b00};
        vecs[1] = '{bits: 7'b1011001, data: 4'b0110, err: 2'b10};
        vecs[2] = '{bits: 7'b1011010, data: 4'b0110, err: 2'b01};
        vecs[3] = '{bits: 7'b1101101, data: 4'b1011, err: 2'b11};
        vecs[4] = '{bits: 7'b1111100, data: 4'b1111, err: 2'b00};

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 8'(bus.out_valid), 8'd0);
        check("rst_data", 8'(bus.data), 8'd0);
        check("rst_err", 8'(bus.err), 8'd0);
        check("rst_overrun", 8'(bus.overrun), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_abort", 8'(bus.abort), 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_zero_ignored", 8'(bus.busy), 8'd0);

        // Table of single frames, consumer always ready
        foreach (vecs[k]) begin
            send_frame(vecs[k].bits, 1'b1);
            check("tbl_valid", 8'(bus.out_valid), 8'd1);
            check("tbl_data", 8'(bus.data), 8'(vecs[k].data));
            check("tbl_err", 8'(bus.err), 8'(vecs[k].err));
            check("tbl_busy", 8'(bus.busy), 8'd0);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("tbl_valid_drop", 8'(bus.out_valid), 8'd0);
        end

        // Backpressure and sticky overrun
        send_frame(7'b1101110, 1'b0);
        check("bp_valid", 8'(bus.out_valid), 8'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("bp_valid_held", 8'(bus.out_valid), 8'd1);
        check("bp_data_held", 8'(bus.data), 8'b1011);
        check("bp_err_held", 8'(bus.err), 8'b00);
        check("bp_overrun", 8'(bus.overrun), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_transfer", 8'(bus.out_valid), 8'd0);
        check("bp_overrun_sticky", 8'(bus.overrun), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_overrun_sticky2", 8'(bus.overrun), 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_overrun_reset", 8'(bus.overrun), 8'd0);

        // Back-to-back: second start bit on the transfer edge
        send_frame(7'b1000000, 1'b1);
        check("b2b_valid_a", 8'(bus.out_valid), 8'd1);
        check("b2b_data_a", 8'(bus.data), 8'b0000);
        check("b2b_err_a", 8'(bus.err), 8'b00);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("b2b_xfer_valid", 8'(bus.out_valid), 8'd0);
        check("b2b_xfer_busy", 8'(bus.busy), 8'd1);
        for (int i = 5; i >= 0; i--) step(1'b0, 1'b1, vecs[4].bits[i], 1'b1);
        check("b2b_valid_b", 8'(bus.out_valid), 8'd1);
        check("b2b_data_b", 8'(bus.data), 8'b1111);
        check("b2b_err_b", 8'(bus.err), 8'b00);
        check("b2b_overrun", 8'(bus.overrun), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame after d2
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid_rst_busy", 8'(bus.busy), 8'd0);
        check("mid_rst_valid", 8'(bus.out_valid), 8'd0);
        check("mid_rst_data", 8'(bus.data), 8'd0);
        check("mid_rst_err", 8'(bus.err), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_idle", 8'(bus.busy), 8'd0);
        send_frame(7'b1010111, 1'b1);
        check("mid_rst_frame_valid", 8'(bus.out_valid), 8'd1);
        check("mid_rst_frame_data", 8'(bus.data), 8'b0101);
        check("mid_rst_frame_err", 8'(bus.err), 8'b00);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Stall after d1
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < TIMEOUT; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("gap_abort_early", 8'(bus.abort), 8'd0);
        check("gap_busy_early", 8'(bus.busy), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PAIR_PARITY_RX_TIMEOUT_EN
        check("to_abort", 8'(bus.abort), 8'd1);
        check("to_busy", 8'(bus.busy), 8'd0);
        check("to_valid", 8'(bus.out_valid), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("to_abort_pulse", 8'(bus.abort), 8'd0);
        check("to_valid_after", 8'(bus.out_valid), 8'd0);
`else
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("nto_busy", 8'(bus.busy), 8'd1);
        check("nto_abort", 8'(bus.abort), 8'd0);
        check("nto_valid", 8'(bus.out_valid), 8'd0);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic against the frame model
        for (int n = 0; n < 3000; n++) begin
            logic r, dv, d, rdy;
            r   = ($urandom_range(0, 199) == 0);
            dv  = ($urandom_range(0, 9) < 7);
            d   = 1'($urandom);
            rdy = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                // occasional long stall to exercise gap handling
                for (int g = 0; g < TIMEOUT + 2; g++) begin
                    step(1'b0, 1'b0, 1'b0, rdy);
                    check("rnd_gap_busy", 8'(bus.busy), 8'(m_bits.size() != 0));
                    check("rnd_gap_abort", 8'(bus.abort), 8'(m_abort));
                end
            end
            step(r, dv, d, rdy);
            check("rnd_valid", 8'(bus.out_valid), 8'(m_hold));
            check("rnd_busy", 8'(bus.busy), 8'(m_bits.size() != 0));
            check("rnd_overrun", 8'(bus.overrun), 8'(m_ovr));
            check("rnd_abort", 8'(bus.abort), 8'(m_abort));
            if (m_hold) begin
                check("rnd_data", 8'(bus.data), 8'(m_data));
                check("rnd_err", 8'(bus.err), 8'(m_err));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
